// File: rtl/fifo_uart_tx_if.sv
// FIFO read port between the write-side FIFO and the serial transmit stage.
// master: the transmitter that pulls bytes; slave: the FIFO that supplies them.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_read;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_read
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_read
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and shifts each entry out LSB-first as an async serial frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to report data
// REQ    | one-cycle FIFO read strobe
// LATCH  | registered FIFO output captured into the shift register
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// PARITY | even-parity bit (parity build only)
// STOP   | stop bit (tx=1); frame_done pulses on the exit edge
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clock,
  input  logic           reset,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif
  localparam logic [2:0] STOP   = 3'd6;

  logic [2:0]            state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic                  baud_end;
  logic                  last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_bit;
`endif

  assign baud_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign shreg_nxt = {1'b0, shreg[DATA_WIDTH-1:1]};

  assign fifo.fifo_read = (state == REQ);
  assign busy           = (state != IDLE);

  // tx is loaded with the value of the state being entered, so it only
  // moves on the edge that starts a new bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo.fifo_empty) state <= REQ;
        end
        REQ: state <= LATCH;
        LATCH: begin
          shreg    <= fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          par_bit  <= ^fifo.fifo_data;
`endif
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= shreg_nxt;
            if (last_bit) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= par_bit;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shreg_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_cnt   <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds bytes, a line-level
// receiver decodes tx and compares each frame against the expected-byte queue.
module tb_fifo_uart_tx;

  localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clock = 1'b0;
  logic reset;
  logic tx, busy, frame_done;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) fifo_if ();

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo       (fifo_if),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_rx     = 0;
  int         rd_count      = 0;
  int         pushed_total  = 0;
  int         last_rd_cyc   = 0;
  int         last_fall_cyc = 0;
  bit         rd_pending    = 0;
  bit         tog_en        = 0;
  bit         tog           = 0;
  logic       empty_prev    = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB first, even parity if built, stop 1.
  function automatic logic [NB-1:0] frame_bits(logic [7:0] b);
    int ones;
    ones = 0;
    frame_bits = '1;
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_bits[i+1] = b[i];
      ones += int'(b[i]);
    end
`ifdef FIFO_UART_TX_PARITY_EN
    frame_bits[9] = ((ones % 2) == 1);
`endif
  endfunction

  task automatic push(logic [7:0] b, bit expect_frame);
    fifo_q.push_back(b);
    pushed_total++;
    if (expect_frame) exp_q.push_back(b);
  endtask

  // FIFO model: registered read data, flag updated just after each edge.
  initial begin
    logic new_empty;
    fifo_if.fifo_data  = '0;
    fifo_if.fifo_empty = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rd_pending) begin
        check("fifo_underflow", (fifo_q.size() == 0), 0);
        if (fifo_q.size() != 0) fifo_if.fifo_data = fifo_q.pop_front();
        rd_pending = 0;
      end
      new_empty = tog_en ? tog : (fifo_q.size() == 0);
      tog = ~tog;
      if (fifo_if.fifo_empty && !new_empty) last_fall_cyc = cyc;
      fifo_if.fifo_empty = new_empty;
    end
  end

  // Read-strobe watcher.
  initial begin
    forever begin
      @(negedge clock);
      if (fifo_if.fifo_read === 1'b1) begin
        rd_count++;
        last_rd_cyc = cyc;
        rd_pending  = 1;
        check("read_after_empty", empty_prev, 0);
      end
      empty_prev = fifo_if.fifo_empty;
    end
  end

  task automatic receive_frame(int s);
    logic [NB-1:0] got;
    logic [7:0]    b;
    logic          v;
    bit            aborted, glitch, fd_seen;
    got = '1; v = 1'b1; aborted = 0; glitch = 0; fd_seen = 0;
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < C; j++) begin
        if (k != 0 || j != 0) @(negedge clock);
        if (reset) begin
          aborted = 1;
          break;
        end
        if (frame_done) fd_seen = 1;
        if (j == 0) v = tx;
        else if (tx !== v) glitch = 1;
      end
      if (aborted) break;
      got[k] = v;
    end
    if (aborted) return;
    @(negedge clock);
    check("frame_done_at_end", frame_done, 1);
    check("frame_done_early", fd_seen, 0);
    check("bit_stable", glitch, 0);
    check("read_to_start", s - last_rd_cyc, 2);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_frame: got bits %0h with no byte expected", got);
    end else begin
      b = exp_q.pop_front();
      check("frame_bits", got, frame_bits(b));
    end
    starts.push_back(s);
    frames_rx++;
  endtask

  // Line monitor: a falling edge on an idle-high line starts a frame.
  initial begin
    logic prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && prev_tx === 1'b1 && tx === 1'b0) receive_frame(cyc);
      prev_tx = tx;
    end
  end

  task automatic wait_frames(int n, int budget);
    int k;
    k = 0;
    while (frames_rx < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("frame_wait_timeout", (frames_rx >= n), 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_read(output int r);
    int k;
    k = 0;
    r = -1;
    while (k < 200) begin
      @(negedge clock);
      if (fifo_if.fifo_read === 1'b1) begin
        r = cyc;
        break;
      end
      k++;
    end
    check("read_wait_timeout", (r >= 0), 1);
  endtask

  initial begin
    int rd0, fr0, r, done_seen, nb;
    bit started;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", {tx, busy, fifo_if.fifo_read, frame_done}, 4'b1000);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("idle_hold", {tx, busy, fifo_if.fifo_read}, 3'b100);
    end

    // Single bytes: launch latency, one read each, parity cases.
    rd0 = rd_count;
    push(8'hA5, 1);
    wait_frames(1, 300);
    check("launch_latency", last_rd_cyc - last_fall_cyc, 1);
    check("single_read_count", rd_count - rd0, 1);
    push(8'h07, 1);
    wait_frames(2, 300);
    check("second_read_count", rd_count - rd0, 2);

    // Back-to-back frames.
    fr0 = frames_rx;
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    rd0 = rd_count;
    started = 0;
    done_seen = 0;
    for (int k = 0; k < 400 && done_seen < 3; k++) begin
      @(negedge clock);
      if (fifo_if.fifo_read) started = 1;
      if (frame_done) begin
        done_seen++;
        check("b2b_busy_in_idle", busy, 0);
      end else if (started) begin
        check("b2b_busy_high", busy, 1);
      end
    end
    check("b2b_done_count", done_seen, 3);
    wait_frames(fr0 + 3, 100);
    check("b2b_read_count", rd_count - rd0, 3);
    nb = starts.size();
    if (nb >= 3) begin
      check("b2b_gap_1", starts[nb-2] - starts[nb-3], NB * C + 3);
      check("b2b_gap_2", starts[nb-1] - starts[nb-2], NB * C + 3);
    end

    // FIFO flag toggling during DATA must not trigger a read.
    fr0 = frames_rx;
    rd0 = rd_count;
    push(8'h5A, 1);
    wait_read(r);
    repeat (2 + C) @(negedge clock);
    tog_en = 1;
    repeat (8 * C) @(negedge clock);
    tog_en = 0;
    wait_frames(fr0 + 1, 200);
    check("toggle_read_count", rd_count - rd0, 1);

    // Reset during data bit 3 of 0xFF, then 0x3C must arrive intact.
    fr0 = frames_rx;
    push(8'hFF, 0);
    wait_read(r);
    repeat (2 + 4 * C + 1) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_read", fifo_if.fifo_read, 0);
    push(8'h3C, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_frames(fr0 + 1, 300);

    // Randomised traffic with random gaps, including bursts.
    fr0 = frames_rx;
    for (int i = 0; i < 20; i++) begin
      push(8'($urandom_range(0, 255)), 1);
      repeat ($urandom_range(0, 60)) @(negedge clock);
    end
    wait_frames(fr0 + 20, 2000);

    check("all_expected_consumed", exp_q.size(), 0);
    check("total_reads", rd_count, pushed_total);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
